// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner
//   Scans an NxN active-low push-button matrix one column at a time,
//   debounces every key and reports a debounced key bitmap plus single-cycle
//   press events. Key index k = N*row + col, matching LED cell indexing.
//
//   Per column: DRIVE (SETTLE_CYCLES cycles, column strobed, rows settle and
//   pass the 2-flop synchronizer), SAMPLE (N cycles, one key per cycle),
//   NEXT (1 cycle, strobes released). Column period SETTLE_CYCLES+N+1.
//
//   Optional feature macro: KEY_SCANNER_TOGGLE_EN
//     defined   : pattern[k] toggles on every press event of key k (cleared by rst)
//     undefined : pattern is a combinational copy of keys
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   ena          scan enable; 0 = idle with all columns released
//   scan_cols    column strobes, active-low one-hot, all 1 = released
//   sense_rows   row returns, active-low, asynchronous
//   keys         debounced key state, 1 = pressed, bit N*row+col
//   press_valid  one-cycle pulse on a debounced 0->1 transition
//   press_index  index of the last press event (held between events)
//   frame_done   one-cycle pulse when column N-1 completes
//   pattern      edit pattern (see macro above)
module key_matrix_scanner #(
    parameter int N              = 8,
    parameter int SETTLE_CYCLES  = 64,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    output logic [N-1:0]            scan_cols,
    input  logic [N-1:0]            sense_rows,
    output logic [N*N-1:0]          keys,
    output logic                    press_valid,
    output logic [$clog2(N*N)-1:0]  press_index,
    output logic                    frame_done,
    output logic [N*N-1:0]          pattern
);

    localparam int CLW = $clog2(N);
    localparam int SW  = $clog2(SETTLE_CYCLES);
    localparam int KW  = $clog2(N*N);
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [N-1:0] ONE_COL = {{(N-1){1'b0}}, 1'b1};

    generate
        if (N < 2) begin : g_bad_n
            $error("key_matrix_scanner: N must be >= 2");
        end
        if (SETTLE_CYCLES < 4) begin : g_bad_settle
            $error("key_matrix_scanner: SETTLE_CYCLES must be >= 4");
        end
        if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
            $error("key_matrix_scanner: DEBOUNCE_SCANS must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRIVE  = 2'b01,
        SAMPLE = 2'b10,
        NEXT   = 2'b11
    } state_t;

    state_t          state_r, state_s;
    logic [CLW-1:0]  col_r, col_s;
    logic [CLW-1:0]  row_r, row_s;
    logic [SW-1:0]   settle_r, settle_s;
    logic [N-1:0]    sync1_r, sync2_r;
    logic [N-1:0]    snap_r;
    logic [N-1:0]    scan_cols_r, scan_s;
    logic            frame_done_r, frame_s;
    logic            snap_load_s;
    logic            proc_s;

    logic [N*N-1:0]  keys_r;
    logic [CW-1:0]   cnt_r [N*N];
    logic            press_valid_r;
    logic [KW-1:0]   press_index_r;

    logic [KW-1:0]   key_idx_s;
    logic            raw_s;
    logic            stable_s;
    logic            flip_s;
    logic [CW-1:0]   cnt_cur_s, cnt_new_s;

    // Two-flop synchronizer for the asynchronous row returns (idle = pulled up).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {N{1'b1}};
            sync2_r <= {N{1'b1}};
        end else begin
            sync1_r <= sense_rows;
            sync2_r <= sync1_r;
        end
    end

    // Scan FSM next-state logic; ena=0 in any active state drops straight to IDLE.
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        row_s       = row_r;
        settle_s    = settle_r;
        snap_load_s = 1'b0;
        proc_s      = 1'b0;
        frame_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ena) begin
                    state_s  = DRIVE;
                    col_s    = {CLW{1'b0}};
                    settle_s = {SW{1'b0}};
                end else begin
                    state_s  = IDLE;
                end
            end
            DRIVE: begin
                if (!ena) begin
                    state_s  = IDLE;
                    col_s    = {CLW{1'b0}};
                    row_s    = {CLW{1'b0}};
                    settle_s = {SW{1'b0}};
                end else if (settle_r == SW'(SETTLE_CYCLES - 1)) begin
                    state_s     = SAMPLE;
                    snap_load_s = 1'b1;
                    settle_s    = {SW{1'b0}};
                    row_s       = {CLW{1'b0}};
                end else begin
                    settle_s = settle_r + SW'(1);
                end
            end
            SAMPLE: begin
                // The row handled this cycle always completes, even if ena drops.
                proc_s = 1'b1;
                if (!ena) begin
                    state_s  = IDLE;
                    col_s    = {CLW{1'b0}};
                    row_s    = {CLW{1'b0}};
                    settle_s = {SW{1'b0}};
                end else if (row_r == CLW'(N - 1)) begin
                    state_s = NEXT;
                    row_s   = {CLW{1'b0}};
                    frame_s = (col_r == CLW'(N - 1));
                end else begin
                    row_s = row_r + CLW'(1);
                end
            end
            NEXT: begin
                settle_s = {SW{1'b0}};
                if (!ena) begin
                    state_s = IDLE;
                    col_s   = {CLW{1'b0}};
                end else if (col_r == CLW'(N - 1)) begin
                    state_s = DRIVE;
                    col_s   = {CLW{1'b0}};
                end else begin
                    state_s = DRIVE;
                    col_s   = col_r + CLW'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                col_s    = {CLW{1'b0}};
                row_s    = {CLW{1'b0}};
                settle_s = {SW{1'b0}};
            end
        endcase
    end

    // Column strobe is decoded from the next state so the registered output tracks the FSM.
    always_comb begin
        if ((state_s == DRIVE) || (state_s == SAMPLE)) begin
            scan_s = ~(ONE_COL << col_s);
        end else begin
            scan_s = {N{1'b1}};
        end
    end

    // Scan FSM state, counters, row snapshot and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            col_r        <= {CLW{1'b0}};
            row_r        <= {CLW{1'b0}};
            settle_r     <= {SW{1'b0}};
            snap_r       <= {N{1'b0}};
            scan_cols_r  <= {N{1'b1}};
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            col_r        <= col_s;
            row_r        <= row_s;
            settle_r     <= settle_s;
            scan_cols_r  <= scan_s;
            frame_done_r <= frame_s;
            if (snap_load_s) begin
                snap_r <= ~sync2_r;
            end else begin
                snap_r <= snap_r;
            end
        end
    end

    // Debounce decision for the single key handled in this SAMPLE cycle.
    always_comb begin
        key_idx_s = KW'(row_r) * KW'(N) + KW'(col_r);
        raw_s     = snap_r[row_r];
        stable_s  = keys_r[key_idx_s];
        cnt_cur_s = cnt_r[key_idx_s];
        flip_s    = 1'b0;
        cnt_new_s = cnt_cur_s;
        if (raw_s == stable_s) begin
            cnt_new_s = {CW{1'b0}};
        end else if (cnt_cur_s == CW'(DEBOUNCE_SCANS - 1)) begin
            flip_s    = 1'b1;
            cnt_new_s = {CW{1'b0}};
        end else begin
            cnt_new_s = cnt_cur_s + CW'(1);
        end
    end

    // Per-key debounce counters, stable key map and press event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_r        <= {(N*N){1'b0}};
            press_valid_r <= 1'b0;
            press_index_r <= {KW{1'b0}};
            for (int i = 0; i < N*N; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            press_valid_r <= proc_s & flip_s & raw_s;
            if (proc_s) begin
                cnt_r[key_idx_s] <= cnt_new_s;
                if (flip_s) begin
                    keys_r[key_idx_s] <= raw_s;
                end
            end
            if (proc_s && flip_s && raw_s) begin
                press_index_r <= key_idx_s;
            end
        end
    end

`ifdef KEY_SCANNER_TOGGLE_EN
    logic [N*N-1:0] pattern_r;

    // Edit pattern: each debounced press flips the matching cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= {(N*N){1'b0}};
        end else if (proc_s && flip_s && raw_s) begin
            pattern_r[key_idx_s] <= ~pattern_r[key_idx_s];
        end else begin
            pattern_r <= pattern_r;
        end
    end

    assign pattern = pattern_r;
`else
    assign pattern = keys_r;
`endif

    assign scan_cols   = scan_cols_r;
    assign keys        = keys_r;
    assign press_valid = press_valid_r;
    assign press_index = press_index_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed testbench for key_matrix_scanner with N=4, SETTLE_CYCLES=4,
// DEBOUNCE_SCANS=2 (column 9 cycles, frame 36 cycles). A behavioural key
// matrix pulls a row low while its column is strobed and the key is held.
module tb_key_matrix_scanner;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [3:0]  scan_cols;
    logic [3:0]  sense_rows;
    logic [15:0] keys;
    logic        press_valid;
    logic [3:0]  press_index;
    logic        frame_done;
    logic [15:0] pattern;

    logic [15:0] key_held;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int press_cnt = 0;
    int frame_cnt = 0;
    int frame_last = 0;
    int frame_prev = 0;
    int pat_diff = 0;
    int idx_log [16];
    int cyc_log [16];
    int t0;
    int pc;
    int fc0;
    int n;

`ifdef KEY_SCANNER_TOGGLE_EN
    localparam logic EXP_P1 = 1'b1;
    localparam logic EXP_P2 = 1'b1;
    localparam logic EXP_P3 = 1'b0;
`else
    localparam logic EXP_P1 = 1'b1;
    localparam logic EXP_P2 = 1'b0;
    localparam logic EXP_P3 = 1'b1;
`endif

    key_matrix_scanner #(
        .N(4),
        .SETTLE_CYCLES(4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .scan_cols(scan_cols),
        .sense_rows(sense_rows),
        .keys(keys),
        .press_valid(press_valid),
        .press_index(press_index),
        .frame_done(frame_done),
        .pattern(pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix model: held key at (r,c) pulls row r low while column c is strobed.
    always_comb begin
        sense_rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_held[4*r+c] && !scan_cols[c]) begin
                    sense_rows[r] = 1'b0;
                end
            end
        end
    end

    // Cycle counter (number of rising edges seen).
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (press_valid) begin
            if (press_cnt < 16) begin
                idx_log[press_cnt] <= int'(press_index);
                cyc_log[press_cnt] <= cyc;
            end
            press_cnt <= press_cnt + 1;
        end
        if (frame_done) begin
            frame_cnt  <= frame_cnt + 1;
            frame_prev <= frame_last;
            frame_last <= cyc;
        end
        if (pattern !== keys) begin
            pat_diff <= pat_diff + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        t0  = cyc;
        rst = 1'b0;
    endtask

    task automatic wait_presses(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (press_cnt < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, press_cnt, target);
    endtask

    initial begin
        rst      = 1'b1;
        ena      = 1'b1;
        key_held = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_scan", scan_cols, 4'b1111);
        chk("rst_keys", keys, 16'h0000);
        chk("rst_press_valid", press_valid, 1'b0);
        chk("rst_press_index", press_index, 4'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_pattern", pattern, 16'h0000);
        key_held = 16'h0040;
        step(1);
        chk("first_strobe", scan_cols, 4'b1110);

        // Held key 6 (row1/col2): flips in frame 2, one event
        wait_presses("key6_press_seen", 1, 120);
        chk("key6_index", idx_log[0], 6);
        chk("key6_cycle", cyc_log[0], t0 + 61);
        chk("key6_keys", keys, 16'h0040);
        step(20);
        chk("frame_cnt", frame_cnt, 2);
        chk("frame_first", frame_prev, t0 + 36);
        chk("frame_period", frame_last - frame_prev, 36);
        step(60);
        chk("key6_single_event", press_cnt, 1);

        // Mid-operation reset, then bounce: key 6 closed during frame 1 only
        do_reset();
        chk("rst2_keys", keys, 16'h0000);
        chk("rst2_scan", scan_cols, 4'b1111);
        pc = press_cnt;
        step(40);
        key_held = 16'h0000;
        step(80);
        chk("bounce_keys", keys, 16'h0000);
        chk("bounce_no_press", press_cnt, pc);

        // Rows 0 and 3 of column 1: two events, ascending row
        key_held = 16'h2002;
        do_reset();
        pc = press_cnt;
        wait_presses("col1_two_presses", pc + 2, 120);
        chk("col1_first_index", idx_log[pc], 1);
        chk("col1_second_index", idx_log[pc+1], 13);
        chk("col1_first_cycle", cyc_log[pc], t0 + 51);
        chk("col1_second_cycle", cyc_log[pc+1], t0 + 54);
        chk("col1_keys", keys, 16'h2002);

        // ena=0 during DRIVE of column 2
        n = 0;
        while (scan_cols !== 4'b1011 && n < 40) begin
            step(1);
            n++;
        end
        chk("col2_drive", scan_cols, 4'b1011);
        fc0 = frame_cnt;
        pc  = press_cnt;
        ena = 1'b0;
        step(1);
        chk("ena0_released", scan_cols, 4'b1111);
        step(5);
        chk("ena0_still_released", scan_cols, 4'b1111);
        chk("ena0_keys_kept", keys, 16'h2002);
        ena = 1'b1;
        step(1);
        chk("restart_strobe", scan_cols, 4'b1110);
        step(30);
        chk("abandon_no_frame_done", frame_cnt, fc0);
        chk("restart_keys_kept", keys, 16'h2002);
        chk("restart_no_press", press_cnt, pc);

        // Press, release, press key 5 (row1/col1)
        key_held = 16'h0020;
        do_reset();
        pc = press_cnt;
        wait_presses("key5_press1", pc + 1, 120);
        step(2);
        chk("key5_keys1", keys, 16'h0020);
        chk("key5_pattern1", pattern[5], EXP_P1);
        key_held = 16'h0000;
        n = 0;
        while (keys[5] !== 1'b0 && n < 120) begin
            step(1);
            n++;
        end
        chk("key5_released", keys, 16'h0000);
        chk("key5_pattern2", pattern[5], EXP_P2);
        chk("release_no_event", press_cnt, pc + 1);
        key_held = 16'h0020;
        wait_presses("key5_press2", pc + 2, 120);
        step(2);
        chk("key5_index", press_index, 4'd5);
        chk("key5_pattern3", pattern[5], EXP_P3);
`ifdef KEY_SCANNER_TOGGLE_EN
        chk("pattern_final", pattern, 16'h0000);
`else
        chk("pattern_eq_keys", pat_diff, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
